// File: rtl/jtdd_mcu_com.sv
// Main-CPU <-> MCU communication glue: control register, shared-RAM bus arbiter, FIRQ latch.
// Optional macro JTDD_MCU_TIMEOUT_EN adds a HALTREQ timeout that bypasses the grant.
module jtdd_mcu_com (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       ctrl_cs,
    input  logic       cpu_wrn,
    input  logic [7:0] cpu_dout,
    input  logic       com_req,
    input  logic       firq_ack,
    input  logic       mcu_ban,
    input  logic       mcu_irqmain,
    output logic       com_cs,
    output logic       cpu_waitn,
    output logic       mcu_haltn,
    output logic       mcu_nmi_set,
    output logic       main_firq,
    output logic [7:0] status
);

    typedef enum logic [2:0] {
        IDLE,
        HALTREQ,
        GRANTED,
        RELEASE,
        BYPASS
    } arb_t;

    arb_t state, next_state;

    logic ctrl_we;
    logic halt_reg;
    logic nmi_q;
    logic ban_low1;
    logic irq_prev;
    logic firq_q;
    logic to_flag;
    logic to_hit;
    logic unused_dout;

    assign ctrl_we     = ctrl_cs & ~cpu_wrn & cen;
    assign unused_dout = ^cpu_dout[7:2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halt_reg <= 1'b0;
            nmi_q    <= 1'b0;
            ban_low1 <= 1'b0;
            irq_prev <= 1'b0;
            firq_q   <= 1'b0;
        end else begin
            if (ctrl_we)
                halt_reg <= cpu_dout[0];
            nmi_q    <= ctrl_we & cpu_dout[1];
            ban_low1 <= ~mcu_ban;
            irq_prev <= mcu_irqmain;
            // a new request wins over a coincident acknowledge
            if (mcu_irqmain & ~irq_prev)
                firq_q <= 1'b1;
            else if (firq_ack)
                firq_q <= 1'b0;
        end
    end

`ifdef JTDD_MCU_TIMEOUT_EN
    logic [7:0] to_cnt;

    // fires on the 255th enabled cycle spent waiting in HALTREQ
    assign to_hit = cen && (to_cnt == 8'd254);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt  <= 8'd0;
            to_flag <= 1'b0;
        end else begin
            if (state != HALTREQ)
                to_cnt <= 8'd0;
            else if (cen)
                to_cnt <= to_cnt + 8'd1;
            if (state == HALTREQ && next_state == BYPASS)
                to_flag <= 1'b1;
            else if (ctrl_we && cpu_dout[2])
                to_flag <= 1'b0;
        end
    end
`else
    assign to_hit  = 1'b0;
    assign to_flag = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        com_cs     = 1'b0;
        cpu_waitn  = ~com_req;
        case (state)
            IDLE: begin
                if (com_req)
                    next_state = HALTREQ;
            end
            HALTREQ: begin
                // bus-available must be seen low on two consecutive edges
                if (~mcu_ban && ban_low1)
                    next_state = GRANTED;
                else if (to_hit)
                    next_state = BYPASS;
            end
            GRANTED: begin
                com_cs    = com_req & ~mcu_ban;
                cpu_waitn = ~(com_req & mcu_ban);
                if (!com_req)
                    next_state = RELEASE;
                else if (mcu_ban)
                    next_state = HALTREQ;
            end
            RELEASE: begin
                next_state = com_req ? HALTREQ : IDLE;
            end
            BYPASS: begin
                cpu_waitn = 1'b1;
                if (!com_req)
                    next_state = RELEASE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign mcu_haltn   = ~(halt_reg | (state != IDLE));
    assign mcu_nmi_set = nmi_q;
    assign main_firq   = firq_q;
    assign status      = {4'b0000, halt_reg, to_flag, firq_q, state == GRANTED};

endmodule
